// File: rtl/ttl_mux_scanner_if.sv
// Bus between the scan controller, its requesters and the shared ttl_74151.
// The master side is the scanner; the slave side is the requester/selector
// environment. WIDTH_IN must match the scanner instance's WIDTH_IN.
interface ttl_mux_scanner_if #(
  parameter int WIDTH_IN = 8
) ();
  localparam int SW = $clog2(WIDTH_IN);

  logic [WIDTH_IN-1:0] Request;
  logic                Y;
  logic                Y_bar;
  logic [SW-1:0]       Select;
  logic                Enable_bar;
  logic [WIDTH_IN-1:0] Grant;
  logic                Busy;
  logic                Sample;
  logic                Sample_valid;
  logic [SW-1:0]       Sample_channel;
  logic                Sample_error;

  modport master (
    input  Request, Y, Y_bar,
    output Select, Enable_bar, Grant, Busy,
           Sample, Sample_valid, Sample_channel, Sample_error
  );

  modport slave (
    output Request, Y, Y_bar,
    input  Select, Enable_bar, Grant, Busy,
           Sample, Sample_valid, Sample_channel, Sample_error
  );
endinterface

// File: rtl/ttl_mux_scanner.sv
// Round-robin scan controller sharing one ttl_74151 among WIDTH_IN requesters.
// Grants one channel, enables the selector for SETTLE_CYCLES, then captures Y
// (and a Y==Y_bar consistency error) tagged with the channel number.
module ttl_mux_scanner #(
  parameter int WIDTH_IN      = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int DELAY_RISE    = 0,
  parameter int DELAY_FALL    = 0
) (
  input  logic              Clk,
  input  logic              Clear_bar,
  ttl_mux_scanner_if.master bus
);
  localparam int SW = $clog2(WIDTH_IN);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  // Outputs are registered, so they already switch only at clock edges; the
  // delay parameters exist for drop-in compatibility with timed TTL models.
  if (WIDTH_IN < 2 || WIDTH_IN > 16 || SETTLE_CYCLES < 1 ||
      DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_params
    $error("ttl_mux_scanner: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, SELECT, SETTLE} state_e;

  state_e              state_q, state_d;
  logic [SW-1:0]       ptr_q, ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SW-1:0]       sel_q, sel_d;
  logic                en_bar_q, en_bar_d;
  logic [WIDTH_IN-1:0] grant_q, grant_d;
  logic                busy_q, busy_d;
  logic                sample_q, sample_d;
  logic                valid_q, valid_d;
  logic [SW-1:0]       chan_q, chan_d;
  logic                err_q, err_d;

  logic [SW-1:0]       pick_any, pick_hi, pick;
  logic                hit_hi;
  logic                settle_done;

  assign settle_done = (cnt_q == CW'(1));

  // Round-robin arbiter: lowest requester at or above the pointer, else wrap
  // to the lowest requester overall. Descending scan lets the lowest win.
  always_comb begin
    pick_any = '0;
    pick_hi  = '0;
    hit_hi   = 1'b0;
    for (int i = WIDTH_IN - 1; i >= 0; i--) begin
      if (bus.Request[i]) begin
        pick_any = SW'(i);
        if (i >= int'(ptr_q)) begin
          pick_hi = SW'(i);
          hit_hi  = 1'b1;
        end
      end
    end
    pick = hit_hi ? pick_hi : pick_any;
  end

  // State register.
  // NOTE: every clocked assignment is non-blocking so all registers update
  // from the same pre-edge values, regardless of statement order.
  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic: IDLE -> SELECT on any request, one cycle in SELECT,
  // then SETTLE until the settle counter reaches its last cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|bus.Request) state_d = SELECT;
      SELECT:  state_d = SETTLE;
      SETTLE:  if (settle_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values for each state.
  always_comb begin
    // NOTE: every variable gets a hold default first so no path through the
    // case can leave one unassigned, which would infer a latch.
    sel_d    = sel_q;
    grant_d  = grant_q;
    busy_d   = busy_q;
    en_bar_d = en_bar_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    sample_d = sample_q;
    chan_d   = chan_q;
    err_d    = err_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.Request) begin
          sel_d        = pick;
          grant_d      = '0;
          grant_d[pick] = 1'b1;
          busy_d       = 1'b1;
        end
      end
      SELECT: begin
        en_bar_d = 1'b0;
        cnt_d    = CW'(SETTLE_CYCLES);
      end
      SETTLE: begin
        cnt_d = cnt_q - CW'(1);
        if (settle_done) begin
          sample_d = bus.Y;
          err_d    = (bus.Y == bus.Y_bar);
          chan_d   = sel_q;
          valid_d  = 1'b1;
          en_bar_d = 1'b1;
          grant_d  = '0;
          busy_d   = 1'b0;
          ptr_d    = (sel_q == SW'(WIDTH_IN - 1)) ? '0 : sel_q + SW'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers; reset abandons any transaction in flight.
  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      ptr_q    <= '0;
      cnt_q    <= '0;
      sel_q    <= '0;
      en_bar_q <= 1'b1;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      sample_q <= 1'b0;
      valid_q  <= 1'b0;
      chan_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      en_bar_q <= en_bar_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      chan_q   <= chan_d;
      err_q    <= err_d;
    end
  end

  assign bus.Select         = sel_q;
  assign bus.Enable_bar     = en_bar_q;
  assign bus.Grant          = grant_q;
  assign bus.Busy           = busy_q;
  assign bus.Sample         = sample_q;
  assign bus.Sample_valid   = valid_q;
  assign bus.Sample_channel = chan_q;
  assign bus.Sample_error   = err_q;
endmodule
